einstein_keyboard: RTL and testbench

EINSTEIN_KEYBOARD -- requirements
Module: einstein_keyboard

---
 rtl/einstein_keyboard.sv | 199 +++++++++++++++++++
 tb/tb_einstein_keyboard.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/einstein_keyboard.sv
// einstein_keyboard: PS/2 receiver and scan-code decoder driving an 8x8 active-low key matrix (rev 1.0).
// Optional odd-parity frame checking is enabled by defining KBD_PARITY_CHECK_EN.
`default_nettype none

module einstein_keyboard (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] kb_row,
  output logic [7:0] kb_col,
  output logic       kb_shift,
  output logic       kb_ctrl,
  output logic       kb_graph,
  output logic       kb_down,
  output logic       byte_stb
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_e;

  logic [1:0]  clk_s_q, dat_s_q;
  logic        filt_clk_q, filt_clk_d;
  logic [2:0]  filt_cnt_q, filt_cnt_d;
  logic        fall, rx_bit, par_ok;

  rx_state_e   state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [14:0] to_cnt_q, to_cnt_d;
  logic        stb_q, stb_d;
  logic [7:0]  rx_byte_q, rx_byte_d;

  logic        release_q, ext_q;
  logic [2:0]  skip_q;
  logic [63:0] key_state_q;
  logic        lshift_q, rshift_q, lctrl_q, rctrl_q, graph_q;
  logic [7:0]  col_or;
  logic [7:0]  kb_col_q;
  logic        kb_down_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      clk_s_q    <= 2'b11;
      dat_s_q    <= 2'b11;
      filt_clk_q <= 1'b1;
      filt_cnt_q <= 3'd0;
    end else begin
      clk_s_q    <= {clk_s_q[0], ps2_clk};
      dat_s_q    <= {dat_s_q[0], ps2_data};
      filt_clk_q <= filt_clk_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // Filtered clock flips on the 8th consecutive sample that disagrees with it.
  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = 3'd0;
    if (clk_s_q[1] != filt_clk_q) begin
      if (filt_cnt_q == 3'd7) filt_clk_d = clk_s_q[1];
      else                    filt_cnt_d = filt_cnt_q + 3'd1;
    end
  end

  assign fall   = filt_clk_q & ~filt_clk_d;
  assign rx_bit = dat_s_q[1];

`ifdef KBD_PARITY_CHECK_EN
  assign par_ok = ^{shift_q, par_q};
`else
  logic unused_par;
  assign unused_par = par_q;
  assign par_ok     = 1'b1;
`endif

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      par_q     <= 1'b0;
      to_cnt_q  <= 15'd0;
      stb_q     <= 1'b0;
      rx_byte_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
      stb_q     <= stb_d;
      rx_byte_q <= rx_byte_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    stb_d     = 1'b0;
    rx_byte_d = rx_byte_q;
    if (state_q == S_IDLE || fall) to_cnt_d = 15'd0;
    else                           to_cnt_d = to_cnt_q + 15'd1;
    case (state_q)
      S_IDLE: if (fall && !rx_bit) begin
        state_d   = S_DATA;
        bit_cnt_d = 3'd0;
      end
      S_DATA: if (fall) begin
        shift_d   = {rx_bit, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = S_PARITY;
      end
      S_PARITY: if (fall) begin
        par_d   = rx_bit;
        state_d = S_STOP;
      end
      S_STOP: if (fall) begin
        state_d = S_IDLE;
        if (rx_bit && par_ok) begin
          stb_d     = 1'b1;
          rx_byte_d = shift_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // 32768 cycles without a falling edge abandons the frame.
    if (state_q != S_IDLE && !fall && to_cnt_q == 15'h7FFF) state_d = S_IDLE;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      release_q   <= 1'b0;
      ext_q       <= 1'b0;
      skip_q      <= 3'd0;
      key_state_q <= 64'd0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      graph_q     <= 1'b0;
    end else if (stb_q) begin
      if (skip_q != 3'd0) begin
        skip_q <= skip_q - 3'd1;
      end else begin
        case (rx_byte_q)
          8'hF0:   release_q <= 1'b1;
          8'hE0:   ext_q     <= 1'b1;
          8'hE1:   skip_q    <= 3'd7;
          default: begin
            release_q <= 1'b0;
            ext_q     <= 1'b0;
            case (rx_byte_q)
              8'h29: if (!ext_q) key_state_q[0]  <= ~release_q;
              8'h1C: if (!ext_q) key_state_q[25] <= ~release_q;
              8'h12: lshift_q <= ~release_q;
              8'h59: rshift_q <= ~release_q;
              8'h14: if (ext_q) rctrl_q <= ~release_q;
                     else       lctrl_q <= ~release_q;
              8'h11: if (!ext_q) graph_q <= ~release_q;
              default: ;
            endcase
          end
        endcase
      end
    end
  end

  always_comb begin
    col_or = 8'd0;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) begin
        col_or[c] = col_or[c] | (key_state_q[r*8+c] & ~kb_row[r]);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      kb_col_q  <= 8'hFF;
      kb_down_q <= 1'b0;
    end else begin
      kb_col_q  <= ~col_or;
      kb_down_q <= |key_state_q;
    end
  end

  assign kb_col   = kb_col_q;
  assign kb_down  = kb_down_q;
  assign kb_shift = ~(lshift_q | rshift_q);
  assign kb_ctrl  = ~(lctrl_q | rctrl_q);
  assign kb_graph = ~graph_q;
  assign byte_stb = stb_q;

endmodule

`default_nettype wire

// File: tb/tb_einstein_keyboard.sv
// tb_einstein_keyboard: directed PS/2 frames against hand-computed matrix and modifier outputs (rev 1.0).
`default_nettype none

module tb_einstein_keyboard;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] kb_row = 8'hFF;
  logic [7:0] kb_col;
  logic       kb_shift, kb_ctrl, kb_graph, kb_down, byte_stb;

  int n_vec = 0;
  int n_err = 0;
  int stb_cnt = 0;
  int snap;

  einstein_keyboard dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .kb_row  (kb_row),
    .kb_col  (kb_col),
    .kb_shift(kb_shift),
    .kb_ctrl (kb_ctrl),
    .kb_graph(kb_graph),
    .kb_down (kb_down),
    .byte_stb(byte_stb)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) if (byte_stb) stb_cnt <= stb_cnt + 1;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      ps2_data = bits[i];
      idle(10);
      ps2_clk = 1'b0;
      idle(20);
      ps2_clk = 1'b1;
      idle(10);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par = 1'b0);
    logic par;
    par = (~^b) ^ bad_par;
    send_bits({1'b1, par, b, 1'b0}, 11);
    idle(5);
  endtask

  task automatic col_at(input string tag, input logic [7:0] row, input logic [7:0] exp);
    @(negedge clk_sys);
    kb_row = row;
    idle(2);
    check(tag, {8'h00, kb_col}, {8'h00, exp});
  endtask

  initial begin
    idle(5);
    check("rst_col",   {8'h00, kb_col}, 16'h00FF);
    check("rst_shift", {15'd0, kb_shift}, 16'd1);
    check("rst_ctrl",  {15'd0, kb_ctrl},  16'd1);
    check("rst_graph", {15'd0, kb_graph}, 16'd1);
    check("rst_down",  {15'd0, kb_down},  16'd0);
    check("rst_stb",   {15'd0, byte_stb}, 16'd0);
    reset_n = 1'b1;
    idle(5);

    // 'A' press/release on row 3
    kb_row = 8'hF7;
    send_frame(8'h1C);
    check("a_col",  {8'h00, kb_col}, 16'h00FD);
    check("a_down", {15'd0, kb_down}, 16'd1);
    check("a_stb",  stb_cnt[15:0], 16'd1);
    send_frame(8'hF0); send_frame(8'h1C);
    check("a_rel_col",  {8'h00, kb_col}, 16'h00FF);
    check("a_rel_down", {15'd0, kb_down}, 16'd0);

    // both shifts held independently
    send_frame(8'h12);
    check("lsh", {15'd0, kb_shift}, 16'd0);
    send_frame(8'h59);
    send_frame(8'hF0); send_frame(8'h12);
    check("rsh_only", {15'd0, kb_shift}, 16'd0);
    check("sh_down",  {15'd0, kb_down},  16'd0);
    send_frame(8'hF0); send_frame(8'h59);
    check("sh_rel",   {15'd0, kb_shift}, 16'd1);
    check("sh_down2", {15'd0, kb_down},  16'd0);

    // ctrl left/right and graph
    send_frame(8'h14);
    send_frame(8'hE0); send_frame(8'h14);
    send_frame(8'hF0); send_frame(8'h14);
    check("rctrl", {15'd0, kb_ctrl}, 16'd0);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h14);
    check("ctrl_rel", {15'd0, kb_ctrl}, 16'd1);
    send_frame(8'hE0); send_frame(8'h11);
    check("ext_graph", {15'd0, kb_graph}, 16'd1);
    send_frame(8'h11);
    check("graph", {15'd0, kb_graph}, 16'd0);
    send_frame(8'hF0); send_frame(8'h11);
    check("graph_rel", {15'd0, kb_graph}, 16'd1);

    // Space + 'A', multi-row OR and 1-cycle row latency
    send_frame(8'h29); send_frame(8'h1C); send_frame(8'h1C);
    col_at("row_f6", 8'hF6, 8'hFC);
    @(negedge clk_sys);
    kb_row = 8'hFF;
    check("row_ff_before", {8'h00, kb_col}, 16'h00FC);
    @(posedge clk_sys); #1;
    check("row_ff_after", {8'h00, kb_col}, 16'h00FF);
    col_at("row_fe", 8'hFE, 8'hFE);
    col_at("row_f7", 8'hF7, 8'hFD);
    send_frame(8'hF0); send_frame(8'h29);
    send_frame(8'hF0); send_frame(8'h29);
    col_at("unheld_rel", 8'hF6, 8'hFD);
    send_frame(8'hF0); send_frame(8'h1C);
    check("all_rel_col",  {8'h00, kb_col}, 16'h00FF);
    check("all_rel_down", {15'd0, kb_down}, 16'd0);

    // E1 swallows the following seven bytes
    kb_row = 8'hFE;
    send_frame(8'hE1);
    for (int i = 0; i < 7; i++) send_frame(8'h29);
    check("e1_skip", {8'h00, kb_col}, 16'h00FF);
    send_frame(8'h29);
    check("e1_after", {8'h00, kb_col}, 16'h00FE);
    send_frame(8'hF0); send_frame(8'h29);

    // partial frame abandoned by timeout
    snap = stb_cnt;
    send_bits(11'h000, 5);
    idle(40000);
    send_frame(8'h29);
    check("to_stb", 16'(stb_cnt - snap), 16'd1);
    check("to_col", {8'h00, kb_col}, 16'h00FE);
    send_frame(8'hF0); send_frame(8'h29);

    // bad parity on 'A'
    kb_row = 8'hF7;
    snap = stb_cnt;
    send_frame(8'h1C, 1'b1);
`ifdef KBD_PARITY_CHECK_EN
    check("par_stb", 16'(stb_cnt - snap), 16'd0);
    check("par_col", {8'h00, kb_col}, 16'h00FF);
`else
    check("par_stb", 16'(stb_cnt - snap), 16'd1);
    check("par_col", {8'h00, kb_col}, 16'h00FD);
    send_frame(8'hF0); send_frame(8'h1C);
`endif

    // reset during a frame with 'A' held
    send_frame(8'h1C);
    check("pre_rst_col", {8'h00, kb_col}, 16'h00FD);
    send_bits(11'h000, 4);
    @(negedge clk_sys);
    reset_n = 1'b0;
    @(posedge clk_sys); #1;
    check("mrst_col",   {8'h00, kb_col}, 16'h00FF);
    check("mrst_down",  {15'd0, kb_down}, 16'd0);
    check("mrst_shift", {15'd0, kb_shift}, 16'd1);
    check("mrst_stb",   {15'd0, byte_stb}, 16'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    idle(3);
    send_frame(8'h29);
    col_at("post_rst", 8'hFE, 8'hFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
